// File: rtl/reg_file_param.sv
// Two-read/one-write register file with registered reads, write-first bypass and a post-reset clear sweep.
// Reads return data 1 cycle after the request. Traffic is accepted only while ready=1. Optional macro: REG_FILE_ZERO_REG_EN (entry 0 reads as zero).
module reg_file_param #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_req,
  output logic              ready,
  input  logic              write_ctrl,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              r1_en,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic [DATA_W-1:0] r1_out,
  output logic              r1_valid,
  input  logic              r2_en,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [DATA_W-1:0] r2_out,
  output logic              r2_valid
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     clear_ptr_q, clear_ptr_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   r1_out_q, r1_out_d;
  logic [DATA_W-1:0]   r2_out_q, r2_out_d;
  logic                r1_valid_q, r1_valid_d;
  logic                r2_valid_q, r2_valid_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic [DATA_W-1:0]   r1_rd_dat;
  logic [DATA_W-1:0]   r2_rd_dat;

  // Write-first: a same-edge write to the read address is forwarded.
  always_comb begin
    r1_rd_dat = (write_ctrl && (write_addr == r1_addr)) ? write_data : mem_q[r1_addr];
    r2_rd_dat = (write_ctrl && (write_addr == r2_addr)) ? write_data : mem_q[r2_addr];
`ifdef REG_FILE_ZERO_REG_EN
    if (r1_addr == '0) r1_rd_dat = '0;
    if (r2_addr == '0) r2_rd_dat = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    ready_d     = ready_q;
    r1_out_d    = r1_out_q;
    r2_out_d    = r2_out_q;
    r1_valid_d  = 1'b0;
    r2_valid_d  = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = write_addr;
    mem_wdata   = write_data;

    case (state_q)
      ST_INIT: begin
        mem_we      = 1'b1;
        mem_waddr   = clear_ptr_q[ADDR_W-1:0];
        mem_wdata   = CLEAR_VAL;
        clear_ptr_d = clear_ptr_q + 1'b1;
        if (clear_ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        // A clear request drops the same-cycle write but still services reads.
        mem_we = write_ctrl && !clear_req;
`ifdef REG_FILE_ZERO_REG_EN
        if (write_addr == '0) mem_we = 1'b0;
`endif
        if (r1_en) begin
          r1_out_d   = r1_rd_dat;
          r1_valid_d = 1'b1;
        end
        if (r2_en) begin
          r2_out_d   = r2_rd_dat;
          r2_valid_d = 1'b1;
        end
        if (clear_req) begin
          state_d     = ST_INIT;
          clear_ptr_d = '0;
          ready_d     = 1'b0;
        end
      end
      default: begin
        state_d     = ST_INIT;
        clear_ptr_d = '0;
        ready_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      clear_ptr_q <= '0;
      ready_q     <= 1'b0;
      r1_out_q    <= '0;
      r2_out_q    <= '0;
      r1_valid_q  <= 1'b0;
      r2_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      ready_q     <= ready_d;
      r1_out_q    <= r1_out_d;
      r2_out_q    <= r2_out_d;
      r1_valid_q  <= r1_valid_d;
      r2_valid_q  <= r2_valid_d;
    end
  end

  // Storage has no reset; the sweep initialises it.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready    = ready_q;
  assign r1_out   = r1_out_q;
  assign r2_out   = r2_out_q;
  assign r1_valid = r1_valid_q;
  assign r2_valid = r2_valid_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param at DATA_W=16, ADDR_W=4: vector table, directed sweep/clear/reset sequences, random traffic vs model.
module tb_reg_file_param;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          clear_req = 1'b0;
  logic          ready;
  logic          write_ctrl = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          r1_en = 1'b0;
  logic [AW-1:0] r1_addr = '0;
  logic [DW-1:0] r1_out;
  logic          r1_valid;
  logic          r2_en = 1'b0;
  logic [AW-1:0] r2_addr = '0;
  logic [DW-1:0] r2_out;
  logic          r2_valid;

  reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL(16'h0000)) dut (
    .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .ready(ready),
    .write_ctrl(write_ctrl), .write_addr(write_addr), .write_data(write_data),
    .r1_en(r1_en), .r1_addr(r1_addr), .r1_out(r1_out), .r1_valid(r1_valid),
    .r2_en(r2_en), .r2_addr(r2_addr), .r2_out(r2_out), .r2_valid(r2_valid)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e1;
    logic [AW-1:0] a1;
    logic          e2;
    logic [AW-1:0] a2;
    logic [DW-1:0] x1;
    logic          v1;
    logic [DW-1:0] x2;
    logic          v2;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] m_out1, m_out2;
  logic          m_v1, m_v2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    write_ctrl = 0; r1_en = 0; r2_en = 0; clear_req = 0;
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
`ifdef REG_FILE_ZERO_REG_EN
    if (a == 0) return '0;
`endif
    if (write_ctrl && write_addr == a) return write_data;
    return model_mem[a];
  endfunction

  // Predicts the RUN-state result of the inputs currently driven, for the edge about to happen.
  task automatic model_cycle();
    m_v1 = r1_en;
    m_v2 = r2_en;
    if (r1_en) m_out1 = model_read(r1_addr);
    if (r2_en) m_out2 = model_read(r2_addr);
    if (write_ctrl) model_mem[write_addr] = write_data;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
    m_v1 = 0; m_v2 = 0;
  endtask

  task automatic check_model(input string tag);
    check({tag, " r1_out"}, 32'(r1_out), 32'(m_out1));
    check({tag, " r1_valid"}, 32'(r1_valid), 32'(m_v1));
    check({tag, " r2_out"}, 32'(r2_out), 32'(m_out2));
    check({tag, " r2_valid"}, 32'(r2_valid), 32'(m_v2));
  endtask

  // Counts sweep edges: ready must stay low for DEPTH-1 edges and rise on edge DEPTH.
  task automatic sweep_timing(input string tag);
    for (int i = 1; i <= DEPTH; i++) begin
      r1_en = 1; r1_addr = 4'(i);
      step();
      check({tag, " ready"}, 32'(ready), 32'(i == DEPTH));
      check({tag, " valid in init"}, 32'(r1_valid), 32'h0);
    end
    r1_en = 0;
    model_clear();
  endtask

  initial begin
    vecs[0] = '{1'b1, 4'd5,  16'hBEEF, 1'b0, 4'd0,  1'b0, 4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  1'b0, 4'd0, 16'hBEEF, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd5,  1'b0, 4'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 4'd9,  16'h1234, 1'b1, 4'd9,  1'b1, 4'd9, 16'h1234, 1'b1, 16'h1234, 1'b1};
    vecs[4] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  1'b1, 4'd9, 16'hBEEF, 1'b1, 16'h1234, 1'b1};
    vecs[5] = '{1'b1, 4'd5,  16'hCAFE, 1'b1, 4'd5,  1'b1, 4'd3, 16'hCAFE, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  1'b1, 4'd5, 16'hCAFE, 1'b0, 16'hCAFE, 1'b1};
    vecs[7] = '{1'b1, 4'd15, 16'h0001, 1'b1, 4'd15, 1'b1, 4'd0, 16'h0001, 1'b1, 16'h0000, 1'b1};

    m_out1 = '0; m_out2 = '0; m_v1 = 0; m_v2 = 0;

    // Reset state
    #3 reset_n = 0;
    #1;
    check("reset ready", 32'(ready), 32'h0);
    check("reset r1_out", 32'(r1_out), 32'h0);
    check("reset r2_out", 32'(r2_out), 32'h0);
    check("reset valids", 32'({r1_valid, r2_valid}), 32'h0);
    @(posedge clock); #1;
    reset_n = 1;
    sweep_timing("initial sweep");

    // Every entry reads as the clear value, one cycle after request
    for (int i = 0; i < DEPTH; i++) begin
      r1_en = 1; r1_addr = 4'(i);
      r2_en = 1; r2_addr = 4'(DEPTH - 1 - i);
      step();
      check("sweep r1_out", 32'(r1_out), 32'h0);
      check("sweep r1_valid", 32'(r1_valid), 32'h1);
      check("sweep r2_out", 32'(r2_out), 32'h0);
      check("sweep r2_valid", 32'(r2_valid), 32'h1);
    end
    idle();
    step();
    m_out1 = 16'h0000; m_out2 = 16'h0000; m_v1 = 0; m_v2 = 0;
    check("valid falls", 32'({r1_valid, r2_valid}), 32'h0);

    // Hand-computed vector table
    for (int i = 0; i < 8; i++) begin
      write_ctrl = vecs[i].we; write_addr = vecs[i].wa; write_data = vecs[i].wd;
      r1_en = vecs[i].e1; r1_addr = vecs[i].a1;
      r2_en = vecs[i].e2; r2_addr = vecs[i].a2;
      model_cycle();
      step();
      check($sformatf("vec%0d r1_out", i), 32'(r1_out), 32'(vecs[i].x1));
      check($sformatf("vec%0d r1_valid", i), 32'(r1_valid), 32'(vecs[i].v1));
      check($sformatf("vec%0d r2_out", i), 32'(r2_out), 32'(vecs[i].x2));
      check($sformatf("vec%0d r2_valid", i), 32'(r2_valid), 32'(vecs[i].v2));
    end
    idle();

    // Clear request: same-cycle write dropped, same-cycle read still serviced
    write_ctrl = 1; write_addr = 4'd3; write_data = 16'hAAAA;
    step();
    write_ctrl = 1; write_addr = 4'd7; write_data = 16'h5555; clear_req = 1;
    r1_en = 1; r1_addr = 4'd3;
    step();
    idle();
    check("clear ready drop", 32'(ready), 32'h0);
    check("clear read pre-clear", 32'(r1_out), 32'hAAAA);
    check("clear read valid", 32'(r1_valid), 32'h1);
    sweep_timing("clear sweep");
    check("init holds r1_out", 32'(r1_out), 32'hAAAA);
    r1_en = 1; r1_addr = 4'd3; r2_en = 1; r2_addr = 4'd7;
    step();
    idle();
    check("cleared addr3", 32'(r1_out), 32'h0);
    check("dropped write addr7", 32'(r2_out), 32'h0);

    // Reset mid-sweep restarts the whole sweep
    write_ctrl = 1; write_addr = 4'd10; write_data = 16'h7777;
    step();
    write_ctrl = 0; r1_en = 1; r1_addr = 4'd10;
    step();
    check("pre-reset read", 32'(r1_out), 32'h7777);
    r1_en = 0; clear_req = 1;
    step();
    clear_req = 0;
    for (int i = 0; i < 6; i++) step();
    reset_n = 0;
    #1;
    check("midsweep reset r1_out", 32'(r1_out), 32'h0);
    check("midsweep reset ready", 32'(ready), 32'h0);
    @(posedge clock); #1;
    reset_n = 1;
    sweep_timing("restart sweep");
    r1_en = 1; r1_addr = 4'd10;
    step();
    idle();
    check("restart cleared addr10", 32'(r1_out), 32'h0);
    m_out1 = r1_out; m_out2 = r2_out; m_v1 = 0; m_v2 = 0;
    m_out1 = 16'h0000;

`ifdef REG_FILE_ZERO_REG_EN
    write_ctrl = 1; write_addr = 4'd0; write_data = 16'hFFFF;
    r1_en = 1; r1_addr = 4'd0;
    step();
    idle();
    check("zero reg bypass", 32'(r1_out), 32'h0);
    r1_en = 1; r1_addr = 4'd0;
    step();
    idle();
    check("zero reg later read", 32'(r1_out), 32'h0);
    m_out1 = 16'h0000;
`endif

    // Random traffic against the model
    step();
    m_v1 = 0; m_v2 = 0;
    m_out2 = r2_valid ? m_out2 : m_out2;
    check_model("random idle");
    for (int n = 0; n < 400; n++) begin
      write_ctrl = 1'($urandom_range(0, 1));
      write_addr = 4'($urandom_range(0, DEPTH - 1));
      write_data = 16'($urandom);
      r1_en = 1'($urandom_range(0, 1));
      r1_addr = ($urandom_range(0, 3) == 0) ? write_addr : 4'($urandom_range(0, DEPTH - 1));
      r2_en = 1'($urandom_range(0, 1));
      r2_addr = ($urandom_range(0, 3) == 0) ? r1_addr : 4'($urandom_range(0, DEPTH - 1));
      model_cycle();
      step();
      check_model("random");
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised two-read/one-write register file; successor to the fixed 8-bit and 16-bit register files.
- Generalised data width and depth.
- Adds registered reads with valid strobes, write-first bypass, and a hardware clear sweep after reset or on request.
- Sits beside the datapath as the operand store; consumers wait for `ready` before issuing traffic.

Parameters:
- DATA_W, 16, width of each entry and of write/read data.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W entries.
- CLEAR_VAL, 0, value (DATA_W bits) written to every entry by the clear sweep.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- clear_req  in  1  synchronous request to re-run the clear sweep; honoured only when ready=1.
- ready  out  1  high when the clear sweep is complete and the file accepts traffic.
- write_ctrl  in  1  write enable.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- r1_en  in  1  read request, port 1.
- r1_addr  in  ADDR_W  read address, port 1.
- r1_out  out  DATA_W  registered read data, port 1.
- r1_valid  out  1  one-cycle strobe; r1_out holds new data.
- r2_en  in  1  read request, port 2.
- r2_addr  in  ADDR_W  read address, port 2.
- r2_out  out  DATA_W  registered read data, port 2.
- r2_valid  out  1  one-cycle strobe; r2_out holds new data.

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n).
- While reset_n=0:
  - state=INIT, clear_ptr=0.
  - ready=0; r1_out=r2_out=0; r1_valid=r2_valid=0.
  - Storage array is not reset asynchronously.
- State INIT:
  - Each rising edge writes CLEAR_VAL to entry clear_ptr, then increments clear_ptr.
  - The edge that writes entry DEPTH-1 moves state to RUN and sets ready=1.
  - ready is therefore first high after edge DEPTH counted from the first edge with reset_n=1.
  - write_ctrl, r1_en, r2_en and clear_req are ignored; valids stay 0; r*_out hold.
- State RUN:
  - Write: at the edge where write_ctrl=1, entry[write_addr] <= write_data.
  - Read: at the edge where rN_en=1, rN_out <= entry[rN_addr] and rN_valid <= 1. Latency is 1 cycle from request edge to data.
  - Read with rN_en=0: rN_valid <= 0 and rN_out holds its value.
  - Write-first bypass: if write_ctrl=1, rN_en=1 and write_addr==rN_addr at the same edge, rN_out <= write_data, not the old contents.
  - Both ports may read the same address in the same cycle; both return identical data.
- clear_req=1 in RUN:
  - Next edge: state=INIT, clear_ptr=0, ready=0.
  - Any write_ctrl in that cycle is dropped; clear wins.
  - Reads requested in that cycle are still serviced with pre-clear data (bypass still applies).
- reset_n asserted mid-sweep or mid-RUN:
  - Immediate return to INIT with outputs zeroed.
  - The full sweep restarts from entry 0.
- Addresses are full-range; no out-of-range case exists.
- clear_ptr is ADDR_W+1 bits wide to detect sweep end without wrap.

Optional Feature:
- Macro REG_FILE_ZERO_REG_EN.
- Defined:
  - Entry 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including the bypass case.
  - The clear sweep may skip entry 0; ready timing is unchanged (still DEPTH edges).
- Undefined: entry 0 is an ordinary entry.

Test Plan:
- Reset release, DATA_W=16, ADDR_W=4: ready=0 for 15 edges and 1 after edge 16; read all 16 entries -> each returns 0x0000 with rN_valid=1 one cycle after request.
- RUN: write 0xBEEF to addr 5, next cycle r1_en=1, r1_addr=5 -> r1_out=0xBEEF, r1_valid=1 for exactly one cycle, then r1_valid=0 and r1_out holds 0xBEEF.
- Same edge: write_ctrl=1, write_addr=9, write_data=0x1234, r1_en=r2_en=1, r1_addr=r2_addr=9 -> both outputs 0x1234 next cycle.
- Write 0xAAAA to addr 3, assert clear_req together with a write of 0x5555 to addr 7 -> ready drops next edge, returns after 16 edges; addr 3 and addr 7 read 0x0000.
- reset_n pulsed low at sweep entry 6 -> outputs 0 immediately; sweep restarts; ready returns 16 edges after release.
- REG_FILE_ZERO_REG_EN defined: write 0xFFFF to addr 0 with a simultaneous read of addr 0 -> r1_out=0x0000; a later read also returns 0x0000.
